apb_master_arbiter: RTL and testbench

Two-requester APB master that shares a single APB completer port, such as the 8-bit register/memory slave on the peripheral bus, between two on-chip requesters. It performs round-robin arbitration, then runs the APB SETUP/ACCESS sequence and waits on `pready`. It also applies a wait-state timeout and returns read data or an error to the granted requester. It sits between requester logic (CPU bridge, DMA) and the APB slave bus.

---
 rtl/apb_pkg.sv | 18 +
 rtl/apb_rr_arbiter.sv | 33 +++
 rtl/apb_master_arbiter.sv | 130 +++++++++++++
 tb/tb_apb_master_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and defaults for the two-requester APB master.
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_t;

  // A TIMEOUT of 0 still needs a 1-bit counter to keep the register legal.
  function automatic int wait_cnt_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin arbiter; on a tie the requester not granted last wins.
module apb_rr_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // Resets to 1 so that requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (|grant) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master shared by two requesters: round-robin grant, SETUP/ACCESS
// sequencing, wait-state timeout and per-requester response pulses.
module apb_master_arbiter
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          req_ready,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                pselx,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready
);

  localparam int CNT_W = wait_cnt_width(TIMEOUT);

  apb_state_t        state;
  logic [1:0]        grant;
  logic [1:0]        grant_q;
  logic              arb_en;
  logic [CNT_W-1:0]  wait_cnt;
  logic              timeout_hit;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Grants are withheld while reset is high so nothing is accepted and lost.
  assign arb_en = (state == APB_IDLE) && !preset;

  apb_rr_arbiter u_arb (
    .clk   (pclk),
    .reset (preset),
    .en    (arb_en),
    .req   (req_valid),
    .grant (grant)
  );

  assign req_ready = grant;

  always_comb begin
    sel_write = req_write[0];
    sel_addr  = req_addr[0 +: ADDR_W];
    sel_wdata = req_wdata[0 +: DATA_W];
    if (grant[1]) begin
      sel_write = req_write[1];
      sel_addr  = req_addr[ADDR_W +: ADDR_W];
      sel_wdata = req_wdata[DATA_W +: DATA_W];
    end
  end

  // True on the ACCESS cycle that would be the TIMEOUT-th one without pready.
  assign timeout_hit = (TIMEOUT != 0) && ((int'(wait_cnt) + 1) >= TIMEOUT);

  always_ff @(posedge pclk) begin
    if (preset) begin
      state     <= APB_IDLE;
      grant_q   <= 2'b00;
      wait_cnt  <= '0;
      pselx     <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 2'b00;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 2'b00;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      case (state)
        APB_IDLE: begin
          if (|grant) begin
            grant_q  <= grant;
            pwrite   <= sel_write;
            paddr    <= sel_addr;
            pwdata   <= sel_wdata;
            pselx    <= 1'b1;
            penable  <= 1'b0;
            wait_cnt <= '0;
            state    <= APB_SETUP;
          end
        end
        APB_SETUP: begin
          penable <= 1'b1;
          state   <= APB_ACCESS;
        end
        APB_ACCESS: begin
          // pready takes priority over a timeout landing on the same cycle.
          if (pready) begin
            rsp_valid <= grant_q;
            rsp_rdata <= pwrite ? '0 : prdata;
            pselx     <= 1'b0;
            penable   <= 1'b0;
            state     <= APB_IDLE;
          end else if (timeout_hit) begin
            rsp_valid <= grant_q;
            rsp_err   <= 1'b1;
            pselx     <= 1'b0;
            penable   <= 1'b0;
            wait_cnt  <= '0;
            state     <= APB_IDLE;
          end else if (TIMEOUT != 0) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: begin
          pselx   <= 1'b0;
          penable <= 1'b0;
          state   <= APB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench: one instance with TIMEOUT=4, one with the timeout disabled.
module tb_apb_master_arbiter;

  typedef struct {
    logic [1:0] id;
    logic [7:0] rdata;
    logic       err;
    int         cyc;
  } exp_t;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  int          cyc = 0;
  int          compared = 0;
  int          mismatched = 0;
  exp_t        exp_q[$];
  exp_t        exp_b[$];

  logic [1:0]  req_valid = 2'b00, req_write = 2'b00;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_ready, rsp_valid;
  logic [7:0]  rsp_rdata, paddr, pwdata, prdata;
  logic        rsp_err, pselx, penable, pwrite, pready;

  logic [1:0]  req_valid_b = 2'b00, req_write_b = 2'b00;
  logic [15:0] req_addr_b = '0, req_wdata_b = '0;
  logic [1:0]  req_ready_b, rsp_valid_b;
  logic [7:0]  rsp_rdata_b, paddr_b, pwdata_b;
  logic [7:0]  prdata_b = 8'h77;
  logic        rsp_err_b, pselx_b, penable_b, pwrite_b;
  logic        pready_b = 1'b0;

  logic [7:0]  mem [256];
  int          acc_cnt = 0;
  int          wait_states = 0;
  bit          never_ready = 1'b0;

  apb_master_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(4)) u_dut (
    .pclk(pclk), .preset(preset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .pselx(pselx), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  apb_master_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(0)) u_dut_b (
    .pclk(pclk), .preset(preset), .req_valid(req_valid_b), .req_write(req_write_b),
    .req_addr(req_addr_b), .req_wdata(req_wdata_b), .req_ready(req_ready_b),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
    .pselx(pselx_b), .penable(penable_b), .pwrite(pwrite_b), .paddr(paddr_b),
    .pwdata(pwdata_b), .prdata(prdata_b), .pready(pready_b)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Simple APB completer: pready after wait_states low ACCESS cycles.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    pready = 1'b0;
    prdata = 8'h00;
    forever begin
      @(posedge pclk);
      #1;
      if (pselx && penable) acc_cnt++;
      else acc_cnt = 0;
      prdata = mem[paddr];
      pready = (acc_cnt > wait_states) && !never_ready;
      if (pready && pwrite) mem[paddr] = pwdata;
    end
  end

  always @(negedge pclk) begin
    exp_t e;
    if (!preset && rsp_valid != 2'b00) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_rsp", {30'd0, rsp_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_output("rsp_id", {30'd0, rsp_valid}, {30'd0, e.id});
        check_output("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.rdata});
        check_output("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        check_output("rsp_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge pclk) begin
    exp_t e;
    if (!preset && rsp_valid_b != 2'b00) begin
      if (exp_b.size() == 0) begin
        check_output("b_unexpected_rsp", {30'd0, rsp_valid_b}, 32'd0);
      end else begin
        e = exp_b.pop_front();
        check_output("b_rsp_id", {30'd0, rsp_valid_b}, {30'd0, e.id});
        check_output("b_rsp_rdata", {24'd0, rsp_rdata_b}, {24'd0, e.rdata});
        check_output("b_rsp_err", {31'd0, rsp_err_b}, {31'd0, e.err});
        check_output("b_rsp_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_drain();
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge pclk);
    @(negedge pclk);
    check_output("rsp_drain", exp_q.size(), 0);
  endtask

  task automatic send_req(input int id, input logic wr, input logic [7:0] addr,
                          input logic [7:0] wdata, output int n);
    bit found = 1'b0;
    n = -1;
    @(posedge pclk);
    #1;
    req_write[id] = wr;
    req_addr[id*8 +: 8] = addr;
    req_wdata[id*8 +: 8] = wdata;
    req_valid[id] = 1'b1;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge pclk);
      if (req_ready[id]) begin
        found = 1'b1;
        n = cyc;
        check_output("grant_onehot", {30'd0, req_ready}, 32'(1 << id));
      end
      @(posedge pclk);
      #1;
    end
    req_valid[id] = 1'b0;
    check_output("grant_seen", {31'd0, found}, 32'd1);
  endtask

  task automatic apply_stimulus(input int id, input logic wr, input logic [7:0] addr,
                                input logic [7:0] wdata, input logic [7:0] exp_rdata,
                                input logic exp_err, input int delay);
    int n;
    exp_t e;
    send_req(id, wr, addr, wdata, n);
    if (n < 0) return;
    e.id = 2'(1 << id);
    e.rdata = exp_rdata;
    e.err = exp_err;
    e.cyc = n + delay;
    exp_q.push_back(e);
    @(negedge pclk);
    check_output("setup_ctrl", {30'd0, pselx, penable}, 32'b10);
    check_output("setup_fields", {15'd0, pwrite, paddr, pwdata}, {15'd0, wr, addr, wdata});
    for (int k = 0; k < delay - 2; k++) begin
      @(negedge pclk);
      check_output("access_ctrl", {30'd0, pselx, penable}, 32'b11);
      check_output("access_fields", {15'd0, pwrite, paddr, pwdata}, {15'd0, wr, addr, wdata});
    end
    @(negedge pclk);
    check_output("end_ctrl", {30'd0, pselx, penable}, 32'b00);
    wait_drain();
  endtask

  task automatic tie_run();
    int g = 0;
    int last = 0;
    exp_t e;
    logic [1:0] seq [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    @(posedge pclk);
    #1;
    req_write = 2'b10;
    req_addr = {8'h20, 8'h10};
    req_wdata = {8'h3C, 8'h00};
    req_valid = 2'b11;
    for (int k = 0; k < 40 && g < 4; k++) begin
      @(negedge pclk);
      if (req_ready != 2'b00) begin
        check_output("tie_grant", {30'd0, req_ready}, {30'd0, seq[g]});
        if (g > 0) check_output("tie_spacing", cyc - last, 3);
        e.id = seq[g];
        e.rdata = seq[g][0] ? 8'hA5 : 8'h00;
        e.err = 1'b0;
        e.cyc = cyc + 3;
        exp_q.push_back(e);
        last = cyc;
        g++;
      end
      @(posedge pclk);
      #1;
    end
    req_valid = 2'b00;
    check_output("tie_count", g, 4);
    wait_drain();
  endtask

  initial begin
    int n;
    int bad;
    bit found;
    exp_t e;

    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check_output("reset_ctrl", {27'd0, pselx, penable, pwrite, rsp_err, (|req_ready)}, 32'd0);
    check_output("reset_data", {6'd0, rsp_valid, rsp_rdata, paddr, pwdata}, 32'd0);
    @(posedge pclk);
    #1;
    preset = 1'b0;

    $display("[TB] zero-wait write then read");
    apply_stimulus(0, 1'b1, 8'h10, 8'hA5, 8'h00, 1'b0, 3);
    apply_stimulus(1, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, 3);

    $display("[TB] tie arbitration");
    tie_run();

    // Three wait states put pready on the same cycle the timeout would hit.
    $display("[TB] wait states");
    wait_states = 3;
    apply_stimulus(1, 1'b0, 8'h20, 8'h99, 8'h3C, 1'b0, 6);
    wait_states = 0;

    $display("[TB] timeout");
    never_ready = 1'b1;
    apply_stimulus(1, 1'b0, 8'h10, 8'h00, 8'h00, 1'b1, 6);
    never_ready = 1'b0;

    $display("[TB] reset during ACCESS");
    never_ready = 1'b1;
    send_req(0, 1'b0, 8'h40, 8'h00, n);
    @(posedge pclk);
    @(negedge pclk);
    check_output("pre_reset_access", {30'd0, pselx, penable}, 32'b11);
    preset = 1'b1;
    @(posedge pclk);
    #1;
    preset = 1'b0;
    never_ready = 1'b0;
    @(negedge pclk);
    check_output("post_reset_ctrl", {27'd0, pselx, penable, pwrite, rsp_err, (|rsp_valid)}, 32'd0);
    check_output("post_reset_data", {8'd0, rsp_rdata, paddr, pwdata}, 32'd0);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge pclk);
      if (rsp_valid != 2'b00) bad++;
    end
    check_output("no_rsp_after_reset", bad, 0);
    @(posedge pclk);
    #1;
    req_addr = {8'h20, 8'h10};
    req_write = 2'b10;
    req_valid = 2'b11;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge pclk);
      if (req_ready != 2'b00) begin
        found = 1'b1;
        check_output("reset_tie_grant", {30'd0, req_ready}, 32'b01);
        e.id = 2'b01;
        e.rdata = 8'hA5;
        e.err = 1'b0;
        e.cyc = cyc + 3;
        exp_q.push_back(e);
      end
      @(posedge pclk);
      #1;
    end
    req_valid = 2'b00;
    check_output("reset_tie_seen", {31'd0, found}, 32'd1);
    wait_drain();

    $display("[TB] timeout disabled");
    @(posedge pclk);
    #1;
    req_addr_b = 16'h0042;
    req_write_b = 2'b00;
    req_valid_b = 2'b01;
    @(negedge pclk);
    check_output("b_grant", {30'd0, req_ready_b}, 32'b01);
    e.id = 2'b01;
    e.rdata = 8'h77;
    e.err = 1'b0;
    e.cyc = cyc + 103;
    exp_b.push_back(e);
    @(posedge pclk);
    #1;
    req_valid_b = 2'b00;
    bad = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge pclk);
      @(negedge pclk);
      if (!(pselx_b && penable_b) || rsp_valid_b != 2'b00) bad++;
    end
    check_output("b_no_abort", bad, 0);
    @(posedge pclk);
    #1;
    pready_b = 1'b1;
    @(posedge pclk);
    #1;
    pready_b = 1'b0;
    for (int k = 0; k < 20 && exp_b.size() != 0; k++) @(posedge pclk);
    @(negedge pclk);
    check_output("b_rsp_drain", exp_b.size(), 0);
    check_output("a_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
